pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Parametrised pipeline control unit for the mycpu core; supersedes the fixed 6-bit load-only stall controller.
//  Merges per-stage stall requests into an N-stage stall vector (PC = stage 0) and sequences exception flush/redirect
//  through a small FSM. Also keeps a saturating stall-cycle performance counter and a stall watchdog.
//  Sits beside IF/ID/EX/MEM/WB; its stall/flush vectors drive every pipeline register, new_pc drives IF.
// PARAMETERS
//  N_STAGES    6   stall/flush vector width; bit0=PC, bit1=IF/ID ... bit N-1=WB
//  PC_W        32  width of redirect PC
//  CNT_W       32  width of stall_cycles performance counter
//  FLUSH_CYC   1   cycles flush is held asserted (>=1)
//  WDOG_LIMIT  1024 consecutive stall cycles before wdog_err; 0 disables watchdog
// PORTS
//  clk           in   1         core clock
//  rst           in   1         synchronous reset, active high
//  stallreq      in   N_STAGES  stallreq[i]=1: stage i cannot advance this cycle (load-use, bru, multi-cycle ex ...)
//  excp_valid    in   1         exception/eret committed this cycle
//  excp_stage    in   $clog2(N_STAGES)  index of stage raising excp_valid
//  excp_target   in   PC_W      handler / return PC
//  cnt_clr       in   1         clear stall_cycles
//  stall         out  N_STAGES  per-stage hold (combinational)
//  flush         out  N_STAGES  per-stage kill (registered)
//  new_pc_valid  out  1         IF must load new_pc next edge (registered)
//  new_pc        out  PC_W      redirect PC (registered)
//  busy          out  1         FSM not in RUN
//  stall_cycles  out  CNT_W     saturating count of cycles with stall[0]=1 in RUN
//  wdog_err      out  1         sticky: stall held >= WDOG_LIMIT consecutive cycles
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RUN; flush=0, new_pc_valid=0, new_pc=0, stall_cycles=0, wdog_err=0, internal counters=0.
//   While rst=1, stall is forced 0.
//  Stall merge (state RUN): k = highest i with stallreq[i]=1; stall[j]=1 for all j<=k, 0 above; no request -> stall=0.
//   Stage-register rule (enforced by the stages, not here): stall[i]=1 & stall[i+1]=0 -> bubble into stage i+1.
//   In FLUSH and REDIRECT, stall=0 (flush overrides).
//  FSM:
//   RUN: excp_valid=1 -> latch excp_target into new_pc, latch mask M = bits 0..excp_stage set;
//        next=FLUSH with flush<=M and flush counter=FLUSH_CYC-1. The stall merge still applies in the exception cycle.
//   FLUSH: flush held = M; counter decrements each cycle; at counter 0 -> REDIRECT, flush<=0, new_pc_valid<=1.
//   REDIRECT: new_pc_valid=1 for exactly 1 cycle -> RUN, new_pc_valid<=0.
//   excp_valid is ignored outside RUN; there is no queueing, and the producer must not re-raise.
//  Latency: excp_valid at cycle t -> flush=M in cycles t+1..t+FLUSH_CYC -> new_pc_valid in cycle t+FLUSH_CYC+1.
//  busy = (state != RUN).
//  excp_stage >= N_STAGES: clamp to N_STAGES-1.
//  stall_cycles: +1 on each edge where state=RUN and stall[0]=1; saturates at all-ones and does not wrap.
//   cnt_clr has priority over increment and clears to 0.
//  Watchdog: run counter +1 per cycle with stall[0]=1, cleared on any cycle with stall[0]=0.
//   When it reaches WDOG_LIMIT, wdog_err<=1 and stays set until rst. The run counter saturates at WDOG_LIMIT.
//  Reset mid-flush/redirect: immediate return to RUN, all registered outputs cleared the next cycle, latched target lost.
// TESTING
//  T1 reset: rst=1 with stallreq=6'b111111 -> stall=0, flush=0, new_pc_valid=0, stall_cycles=0.
//  T2 merge: stallreq=6'b000100 -> stall=6'b000111.
//   stallreq=6'b001010 -> stall=6'b001111.
//   stallreq=0 -> stall=0.
//   After 5 stalled cycles, stall_cycles=5.
//  T3 exception: FLUSH_CYC=2, excp_valid at t with excp_stage=4, target=32'hBFC00380
//   -> flush=6'b011111 at t+1,t+2; new_pc_valid=1 with new_pc=32'hBFC00380 at t+3; busy=0 at t+4.
//  T4 exception+stall together: stallreq=6'b001000 with excp_valid in the same cycle
//   -> stall=6'b001111 that cycle; stall=0 during FLUSH.
//   A second excp_valid during FLUSH is ignored; exactly one redirect.
//  T5 counters: CNT_W=4, stall held 20 cycles -> stall_cycles=4'hF.
//   cnt_clr together with a stall -> 0.
//   WDOG_LIMIT=8: stall 7 cycles then release -> wdog_err=0.
//   Stall 8 cycles -> wdog_err=1, held after release.
//  T6 reset in FLUSH: rst asserted at t+1 of T3 -> next cycle flush=0, no new_pc_valid, state RUN.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall merge, exception flush/redirect sequencing,
// stall-cycle performance counter and stall watchdog.
module pipe_stall_ctrl #(
  parameter int N_STAGES   = 6,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int FLUSH_CYC  = 1,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_STAGES-1:0]         stallreq,
  input  logic                        excp_valid,
  input  logic [$clog2(N_STAGES)-1:0] excp_stage,
  input  logic [PC_W-1:0]             excp_target,
  input  logic                        cnt_clr,
  output logic [N_STAGES-1:0]         stall,
  output logic [N_STAGES-1:0]         flush,
  output logic                        new_pc_valid,
  output logic [PC_W-1:0]             new_pc,
  output logic                        busy,
  output logic [CNT_W-1:0]            stall_cycles,
  output logic                        wdog_err
);

  localparam int SW = $clog2(N_STAGES);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int WW = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    REDIRECT
  } state_t;

  state_t              state_q, state_d;
  logic [N_STAGES-1:0] flush_q, flush_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                npv_q, npv_d;
  logic [PC_W-1:0]     newpc_q, newpc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]       run_q, run_d;
  logic                err_q, err_d;

  logic [SW-1:0]       stage_c;
  logic [N_STAGES-1:0] mask;
  logic                acc;

  // Each stage holds if it or any younger-indexed-higher stage requests.
  always_comb begin
    stall = '0;
    acc   = 1'b0;
    if (!rst && state_q == RUN) begin
      for (int j = N_STAGES - 1; j >= 0; j--) begin
        acc      = acc | stallreq[j];
        stall[j] = acc;
      end
    end
  end

  always_comb begin
    stage_c = excp_stage;
    if (32'(excp_stage) > 32'(N_STAGES - 1)) begin
      stage_c = SW'(N_STAGES - 1);
    end
    mask = '0;
    for (int j = 0; j < N_STAGES; j++) begin
      mask[j] = (32'(j) <= 32'(stage_c));
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    fcnt_d  = fcnt_q;
    npv_d   = 1'b0;
    newpc_d = newpc_q;
    unique case (state_q)
      RUN: begin
        if (excp_valid) begin
          newpc_d = excp_target;
          flush_d = mask;
          fcnt_d  = FW'(FLUSH_CYC - 1);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = REDIRECT;
          flush_d = '0;
          npv_d   = 1'b1;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (state_q == RUN && stall[0] && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    run_d = '0;
    if (stall[0]) begin
      run_d = (run_q == WW'(WDOG_LIMIT)) ? run_q : run_q + 1'b1;
    end
    err_d = err_q | ((WDOG_LIMIT != 0) && (run_d == WW'(WDOG_LIMIT)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      flush_q <= '0;
      fcnt_q  <= '0;
      npv_q   <= 1'b0;
      newpc_q <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      fcnt_q  <= fcnt_d;
      npv_q   <= npv_d;
      newpc_q <= newpc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc_valid = npv_q;
  assign new_pc       = newpc_q;
  assign busy         = (state_q != RUN);
  assign stall_cycles = cnt_q;
  assign wdog_err     = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: cycle-indexed reference model plus
// directed literal checks and randomized traffic.
module tb_pipe_stall_ctrl;

  localparam int N  = 6;
  localparam int F  = 2;
  localparam int WL = 8;
  localparam int CM = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        excp_valid;
  logic [2:0]  excp_stage;
  logic [31:0] excp_target;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic [5:0]  flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        busy;
  logic [3:0]  stall_cycles;
  logic        wdog_err;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .N_STAGES(N), .PC_W(32), .CNT_W(4),
    .FLUSH_CYC(F), .WDOG_LIMIT(WL)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .excp_valid(excp_valid), .excp_stage(excp_stage),
    .excp_target(excp_target), .cnt_clr(cnt_clr),
    .stall(stall), .flush(flush),
    .new_pc_valid(new_pc_valid), .new_pc(new_pc),
    .busy(busy), .stall_cycles(stall_cycles),
    .wdog_err(wdog_err)
  );

  int errors = 0;
  int checks = 0;

  // Model: the accepted exception cycle ta defines the whole
  // flush/redirect window by plain cycle arithmetic.
  int          cyc    = 0;
  int          ta     = -100;
  logic [5:0]  m_mask = '0;
  logic [31:0] m_pc   = '0;
  int          m_cnt  = 0;
  int          m_run  = 0;
  bit          m_err  = 1'b0;

  function automatic bit m_busy();
    return (cyc >= ta + 1) && (cyc <= ta + F + 1);
  endfunction

  function automatic logic [5:0] m_stall();
    logic [5:0] s;
    int k;
    s = '0;
    k = -1;
    if (rst || m_busy()) return '0;
    for (int i = 0; i < N; i++) if (stallreq[i]) k = i;
    for (int j = 0; j < N; j++) s[j] = (j <= k);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic sample();
    logic [5:0] ef;
    @(negedge clk);
    ef = ((cyc >= ta + 1) && (cyc <= ta + F)) ? m_mask : 6'b0;
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("flush", 32'(flush), 32'(ef));
    chk("new_pc_valid", 32'(new_pc_valid), 32'(cyc == ta + F + 1));
    chk("new_pc", new_pc, m_pc);
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    chk("wdog_err", 32'(wdog_err), 32'(m_err));
  endtask

  task automatic adv();
    logic [5:0] s;
    int st;
    if (rst) begin
      ta = -100; m_pc = '0; m_cnt = 0; m_run = 0; m_err = 1'b0;
    end else begin
      s = m_stall();
      if (!m_busy() && excp_valid) begin
        st = (excp_stage > 3'd5) ? 5 : int'(excp_stage);
        ta = cyc;
        m_pc = excp_target;
        m_mask = '0;
        for (int j = 0; j <= st; j++) m_mask[j] = 1'b1;
      end
      if (cnt_clr) m_cnt = 0;
      else if (s[0] && m_cnt < CM) m_cnt++;
      if (s[0]) m_run = (m_run < WL) ? m_run + 1 : WL;
      else m_run = 0;
      if (m_run == WL) m_err = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stallreq = '0; excp_valid = 1'b0; cnt_clr = 1'b0;
    excp_stage = '0; excp_target = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    sample(); adv();
    rst = 1'b0;
  endtask

  int npv_n;

  initial begin
    rst = 1'b1;
    idle();
    stallreq = '1;
    @(posedge clk);
    #1;

    // T1 reset
    sample();
    chk("t1_stall", 32'(stall), 32'h0);
    adv();
    rst = 1'b0;
    stallreq = '0;
    sample();
    chk("t1_flush", 32'(flush), 32'h0);
    chk("t1_npv", 32'(new_pc_valid), 32'h0);
    chk("t1_cnt", 32'(stall_cycles), 32'h0);
    adv();

    // T2 merge and counting
    do_reset();
    stallreq = 6'b000100;
    sample(); chk("t2_m1", 32'(stall), 32'h07); adv();
    stallreq = 6'b001010;
    sample(); chk("t2_m2", 32'(stall), 32'h0F); adv();
    stallreq = 6'b000001;
    repeat (3) begin sample(); adv(); end
    stallreq = '0;
    sample();
    chk("t2_m0", 32'(stall), 32'h0);
    chk("t2_cnt5", 32'(stall_cycles), 32'd5);
    adv();

    // T3 exception sequence
    do_reset();
    excp_valid = 1'b1; excp_stage = 3'd4; excp_target = 32'hBFC00380;
    sample(); adv();
    idle();
    sample(); chk("t3_fl1", 32'(flush), 32'h1F); adv();
    sample(); chk("t3_fl2", 32'(flush), 32'h1F); adv();
    sample();
    chk("t3_npv", 32'(new_pc_valid), 32'h1);
    chk("t3_pc", new_pc, 32'hBFC00380);
    adv();
    sample(); chk("t3_busy", 32'(busy), 32'h0); adv();

    // T4 exception with stall, re-raise ignored
    do_reset();
    stallreq = 6'b001000;
    excp_valid = 1'b1; excp_stage = 3'd2; excp_target = 32'h0000_1234;
    sample(); chk("t4_st", 32'(stall), 32'h0F); adv();
    excp_target = 32'h0000_5555;
    sample(); chk("t4_st0", 32'(stall), 32'h0); adv();
    excp_valid = 1'b0;
    npv_n = 0;
    repeat (5) begin
      sample();
      if (new_pc_valid) begin
        npv_n++;
        chk("t4_pc", new_pc, 32'h0000_1234);
      end
      adv();
    end
    chk("t4_one_redirect", 32'(npv_n), 32'd1);
    idle();

    // T5 counters
    do_reset();
    stallreq = 6'b000001;
    repeat (20) begin sample(); adv(); end
    sample();
    chk("t5_sat", 32'(stall_cycles), 32'hF);
    chk("t5_wd20", 32'(wdog_err), 32'h1);
    cnt_clr = 1'b1;
    adv();
    cnt_clr = 1'b0; stallreq = '0;
    sample(); chk("t5_clr", 32'(stall_cycles), 32'h0); adv();
    do_reset();
    stallreq = 6'b000010;
    repeat (7) begin sample(); adv(); end
    stallreq = '0;
    sample(); chk("t5_wd7", 32'(wdog_err), 32'h0); adv();
    stallreq = 6'b100000;
    repeat (8) begin sample(); adv(); end
    stallreq = '0;
    sample(); chk("t5_wd8", 32'(wdog_err), 32'h1); adv();
    sample(); chk("t5_wdh", 32'(wdog_err), 32'h1); adv();

    // T6 reset during flush
    do_reset();
    excp_valid = 1'b1; excp_stage = 3'd4; excp_target = 32'hBFC00380;
    sample(); adv();
    idle();
    rst = 1'b1;
    sample(); adv();
    rst = 1'b0;
    sample();
    chk("t6_fl", 32'(flush), 32'h0);
    chk("t6_npv", 32'(new_pc_valid), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    adv();
    sample(); chk("t6_npv2", 32'(new_pc_valid), 32'h0); adv();

    // Stage index clamp
    excp_valid = 1'b1; excp_stage = 3'd7; excp_target = 32'h8000_0000;
    sample(); adv();
    idle();
    sample(); chk("clamp_fl", 32'(flush), 32'h3F); adv();
    repeat (3) begin sample(); adv(); end

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(99) == 0);
      excp_valid  = ($urandom_range(9) == 0);
      excp_stage  = 3'($urandom_range(7));
      excp_target = $urandom;
      cnt_clr     = ($urandom_range(49) == 0);
      case ($urandom_range(3))
        0: stallreq = '0;
        1: stallreq = 6'($urandom);
        2: stallreq = 6'b1 << $urandom_range(5);
        default: stallreq = 6'b000001;
      endcase
      sample(); adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
